polyveck_pack_w1_seq: RTL and testbench

//  Sequential controller that packs the K-poly w1 vector into its 4-bit/coeff byte string.

---
 rtl/polyveck_pack_w1_seq.sv | 166 ++++++++++++++++
 tb/tb_polyveck_pack_w1_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/polyveck_pack_w1_seq.sv
// polyveck_pack_w1_seq
// Packs a K-polynomial w1 vector into a string of bytes with 4 bits per
// coefficient. The block reads the coefficient RAM one word per cycle. The
// RAM has a 1-cycle read latency. The block writes packed bytes to a byte RAM,
// where byte j = {c[2j+1][3:0], c[2j][3:0]}.
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   start         1-cycle request, honoured only while idle
//   busy          high from the first read cycle through the last byte write
//   done          1-cycle pulse after the last byte write
//   range_err     sticky flag: a coefficient had nonzero bits above [3:0]
//   coef_ren      coefficient RAM read enable
//   coef_raddr    coefficient RAM read address (poly i, coeff n at i*N+n)
//   coef_rdata    coefficient RAM read data, valid the cycle after coef_ren
//   byte_we       byte RAM write enable
//   byte_waddr    byte RAM write address (poly i, byte j at i*N/2+j)
//   byte_wdata    packed byte
module polyveck_pack_w1_seq #(
  parameter int K      = 6,
  parameter int N      = 256,
  parameter int COEF_W = 32,
  parameter int AW_IN  = 11,
  parameter int AW_OUT = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              range_err,
  output logic              coef_ren,
  output logic [AW_IN-1:0]  coef_raddr,
  input  logic [COEF_W-1:0] coef_rdata,
  output logic              byte_we,
  output logic [AW_OUT-1:0] byte_waddr,
  output logic [7:0]        byte_wdata
);

  localparam int               TOTAL     = K * N;
  localparam logic [AW_IN-1:0] LAST_ADDR = AW_IN'(TOTAL - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state;
  state_t             next_state;
  logic               start_acc;
  logic               drain_cnt;
  logic               rd_vld;
  logic [AW_IN-1:0]   rd_addr;
  logic [3:0]         low_nib;

  // A coefficient is out of range when any bit above the packed nibble is set.
  function automatic logic upper_nonzero(input logic [COEF_W-1:0] w);
    return |w[COEF_W-1:4];
  endfunction

  assign start_acc = (state == S_IDLE) && start;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. DRAIN lasts two cycles, which lets the last two reads
  // retire and the final byte be written before done is asserted.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start) next_state = S_READ;
        else       next_state = S_IDLE;
      end
      S_READ: begin
        if (coef_raddr == LAST_ADDR) next_state = S_DRAIN;
        else                         next_state = S_READ;
      end
      S_DRAIN: begin
        if (drain_cnt) next_state = S_DONE;
        else           next_state = S_DRAIN;
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Moore output decode. These outputs come straight from the state flops.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    coef_ren = 1'b0;
    case (state)
      S_IDLE:  begin busy = 1'b0; done = 1'b0; coef_ren = 1'b0; end
      S_READ:  begin busy = 1'b1; done = 1'b0; coef_ren = 1'b1; end
      S_DRAIN: begin busy = 1'b1; done = 1'b0; coef_ren = 1'b0; end
      S_DONE:  begin busy = 1'b0; done = 1'b1; coef_ren = 1'b0; end
      default: begin busy = 1'b0; done = 1'b0; coef_ren = 1'b0; end
    endcase
  end

  // Read-address counter and drain counter. The address holds its last
  // value once reading has stopped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coef_raddr <= '0;
      drain_cnt  <= 1'b0;
    end else begin
      if (start_acc) begin
        coef_raddr <= '0;
      end else if ((state == S_READ) && (coef_raddr != LAST_ADDR)) begin
        coef_raddr <= coef_raddr + AW_IN'(1);
      end
      if (state == S_DRAIN) drain_cnt <= ~drain_cnt;
      else                  drain_cnt <= 1'b0;
    end
  end

  // Tracks which address the current coef_rdata belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld  <= 1'b0;
      rd_addr <= '0;
    end else begin
      rd_vld  <= coef_ren;
      rd_addr <= coef_raddr;
    end
  end

  // Packing pipeline. Data from an even address is held as the low nibble.
  // Data from an odd address completes the byte, which is written next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      low_nib    <= 4'd0;
      byte_we    <= 1'b0;
      byte_waddr <= '0;
      byte_wdata <= 8'd0;
      range_err  <= 1'b0;
    end else begin
      byte_we <= 1'b0;
      if (rd_vld) begin
        if (rd_addr[0] == 1'b0) begin
          low_nib <= coef_rdata[3:0];
        end else begin
          byte_we    <= 1'b1;
          byte_wdata <= {coef_rdata[3:0], low_nib};
          byte_waddr <= AW_OUT'(rd_addr >> 1);
        end
      end
      if (start_acc) begin
        range_err <= 1'b0;
      end else if (rd_vld && upper_nonzero(coef_rdata)) begin
        range_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_polyveck_pack_w1_seq.sv
module tb_polyveck_pack_w1_seq;

  localparam int K     = 6;
  localparam int N     = 256;
  localparam int TOTAL = K * N;
  localparam int NB    = TOTAL / 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic        range_err;
  logic        coef_ren;
  logic [10:0] coef_raddr;
  logic [31:0] coef_rdata = 32'd0;
  logic        byte_we;
  logic [9:0]  byte_waddr;
  logic [7:0]  byte_wdata;

  polyveck_pack_w1_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .range_err  (range_err),
    .coef_ren   (coef_ren),
    .coef_raddr (coef_raddr),
    .coef_rdata (coef_rdata),
    .byte_we    (byte_we),
    .byte_waddr (byte_waddr),
    .byte_wdata (byte_wdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem    [0:TOTAL-1];
  logic [7:0]  obytes [0:NB-1];

  // Coefficient RAM: 1-cycle read latency
  always @(posedge clk) begin
    if (coef_ren) coef_rdata <= mem[coef_raddr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   start_cyc = 0;
  logic clr;
  int   wr_cnt, done_cnt, done_rel, first_we, last_we, exp_addr;
  int   addr_err, pair_err, busy_cnt, re_rel;
  logic prev_we;
  int   ncmp = 0;
  int   nfail = 0;

  // Output monitor, sampled on the falling edge; rel = cycle index after start
  always @(negedge clk) begin
    if (clr) begin
      wr_cnt <= 0; done_cnt <= 0; done_rel <= 0; first_we <= 0; last_we <= 0;
      exp_addr <= 0; addr_err <= 0; pair_err <= 0; busy_cnt <= 0; re_rel <= 0;
      prev_we <= 1'b0;
    end else begin
      if (byte_we) begin
        obytes[byte_waddr] <= byte_wdata;
        if (int'(byte_waddr) != exp_addr) addr_err <= addr_err + 1;
        exp_addr <= exp_addr + 1;
        if (wr_cnt == 0) first_we <= cyc - start_cyc + 1;
        last_we <= cyc - start_cyc + 1;
        wr_cnt  <= wr_cnt + 1;
        if (prev_we) pair_err <= pair_err + 1;
      end
      prev_we <= byte_we;
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_rel <= cyc - start_cyc + 1;
      end
      if (busy) busy_cnt <= busy_cnt + 1;
      if (range_err && (re_rel == 0)) re_rel <= cyc - start_cyc + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Pulse start in cycle 0; returns #1 into cycle 1
  task automatic kick();
    @(posedge clk); #1;
    clr   = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start_cyc = cyc;
    clr   = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (done_cnt != 0) break;
    end
    chk({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic fill_pattern();
    for (int n = 0; n < TOTAL; n++) mem[n] = 32'(n % 16);
  endtask

  function automatic int count_byte_errs();
    int e;
    logic [7:0] ex;
    e = 0;
    for (int j = 0; j < NB; j++) begin
      ex = {mem[2*j+1][3:0], mem[2*j][3:0]};
      if (obytes[j] !== ex) e++;
    end
    return e;
  endfunction

  int saved;
  logic [7:0] b;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    clr   = 1'b1;
    fill_pattern();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  32'(busy),       32'd0);
    chk("rst_done",  32'(done),       32'd0);
    chk("rst_rerr",  32'(range_err),  32'd0);
    chk("rst_ren",   32'(coef_ren),   32'd0);
    chk("rst_we",    32'(byte_we),    32'd0);
    chk("rst_raddr", 32'(coef_raddr), 32'd0);
    chk("rst_waddr", 32'(byte_waddr), 32'd0);
    chk("rst_wdata", 32'(byte_wdata), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of READ, in cycle 500
    kick();
    repeat (499) @(posedge clk);
    #1;
    chk("mid_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_busy",  32'(busy),       32'd0);
    chk("mid_ren",   32'(coef_ren),   32'd0);
    chk("mid_we",    32'(byte_we),    32'd0);
    chk("mid_raddr", 32'(coef_raddr), 32'd0);
    chk("mid_waddr", 32'(byte_waddr), 32'd0);
    chk("mid_wdata", 32'(byte_wdata), 32'd0);
    chk("mid_done",  32'(done),       32'd0);
    saved = wr_cnt;
    chk("mid_writes_before", 32'(saved), 32'd248);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("mid_no_more_writes", 32'(wr_cnt), 32'(saved));
    chk("mid_no_done",        32'(done_cnt), 32'd0);
    chk("mid_idle_ren",       32'(coef_ren), 32'd0);

    // Full run with c[n] = n mod 16
    fill_pattern();
    kick();
    wait_done("pat");
    chk("pat_writes",    32'(wr_cnt),   32'd768);
    chk("pat_done_cnt",  32'(done_cnt), 32'd1);
    chk("pat_done_cyc",  32'(done_rel), 32'd1539);
    chk("pat_first_we",  32'(first_we), 32'd4);
    chk("pat_last_we",   32'(last_we),  32'd1538);
    chk("pat_busy_cyc",  32'(busy_cnt), 32'd1538);
    chk("pat_addr_seq",  32'(addr_err), 32'd0);
    chk("pat_alt_we",    32'(pair_err), 32'd0);
    b = obytes[0];
    chk("pat_byte0", 32'(b), 32'h10);
    b = obytes[7];
    chk("pat_byte7", 32'(b), 32'hFE);
    chk("pat_all_bytes",  32'(count_byte_errs()), 32'd0);
    chk("pat_hold_raddr", 32'(coef_raddr), 32'd1535);
    chk("pat_hold_waddr", 32'(byte_waddr), 32'd767);
    chk("pat_hold_wdata", 32'(byte_wdata), 32'hFE);
    chk("pat_busy_after", 32'(busy),       32'd0);
    chk("pat_rerr",       32'(range_err),  32'd0);

    // Poly boundary plus an out-of-range coefficient at address 100
    mem[255] = 32'h0000_000F;
    mem[256] = 32'h0000_0003;
    mem[257] = 32'h0000_000A;
    mem[100] = 32'h0000_0013;
    kick();
    wait_done("bnd");
    b = obytes[127];
    chk("bnd_byte127", 32'(b), 32'hFE);
    b = obytes[128];
    chk("bnd_byte128", 32'(b), 32'hA3);
    b = obytes[50];
    chk("rng_byte50",  32'(b), 32'h53);
    chk("rng_set_cyc", 32'(re_rel),    32'd103);
    chk("rng_held",    32'(range_err), 32'd1);
    chk("bnd_all",     32'(count_byte_errs()), 32'd0);

    // Start pulses at cycles 10 and 800 are ignored; this start clears range_err
    fill_pattern();
    kick();
    chk("rng_cleared", 32'(range_err), 32'd0);
    repeat (9) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (789) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ign");
    chk("ign_writes",   32'(wr_cnt),   32'd768);
    chk("ign_done_cnt", 32'(done_cnt), 32'd1);
    chk("ign_done_cyc", 32'(done_rel), 32'd1539);
    chk("ign_addr_seq", 32'(addr_err), 32'd0);
    chk("ign_rerr",     32'(range_err), 32'd0);

    // Random legal vectors against the reference packer
    for (int v = 0; v < 20; v++) begin
      for (int n = 0; n < TOTAL; n++) mem[n] = 32'($urandom_range(0, 15));
      kick();
      wait_done("rnd");
      chk("rnd_bytes",  32'(count_byte_errs()), 32'd0);
      chk("rnd_writes", 32'(wr_cnt), 32'd768);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
